// File: rtl/ctrl_lgc.sv
// ---------------------------------------------------------------------------
// ctrl_lgc
//
// Control logic of an 8259-style programmable interrupt controller.
// Decodes initialisation (ICW1..ICW4) and operation (OCW1..OCW3) command
// writes, holds the mode flags and sequences the two-pulse INTA handshake.
// Drives the interrupt request to the CPU, the set/clear pulses for the
// in-service register and the data-bus driver enable for the vector cycle.
//
// Optional feature macro: CTRL_LGC_AEOI_EN
//   defined     - ICW4 D1 is latched into ar, and the end of the second INTA
//                 pulse issues an automatic eoi pulse when ar is set.
//   not defined - ar is tied low, ICW4 D1 is ignored, and eoi comes only
//                 from an OCW2 end-of-interrupt command.
//
// Ports
//   clk      in   1  system clock, all state updates on the rising edge
//   reset    in   1  asynchronous, active-high reset
//   D        in   8  write data bus
//   a0       in   1  address bit A0 of the current access
//   wrflg    in   1  write strobe, one cycle per write
//   rdflag   in   1  read strobe, one cycle per read
//   inta     in   1  interrupt acknowledge from the CPU, active-high level
//   R        in   8  resolved request vector, lowest set bit wins
//   Mask     in   8  interrupt mask register contents (1 = masked)
//   isr      in   1  some ISR bit is set
//   irr      in   1  an unmasked request is pending in the IRR
//   isprior  in   1  pending request outranks the highest in-service level
//   S        in   1  SP/EN strap: 1 = master, 0 = slave
//   CLsig    in   1  cascade match: this slave is addressed on CAS lines
//   intr     out  1  interrupt request to the CPU ("int" is a reserved word)
//   ino      out  1  one-cycle pulse: set the ISR bit of level Y
//   en       out  1  data-bus driver enable for vector output
//   rwadr    out  3  register targeted by the last access (7 = none)
//   Y        out  3  index of the lowest set bit of (R & ~Mask), 0 if none
//   buff     out  1  buffered-mode flag (ICW4 D3)
//   LTIM     out  1  level-trigger flag (ICW1 D3)
//   eoi      out  1  one-cycle pulse: clear the ISR bit
//   ar       out  1  automatic-EOI flag (ICW4 D1)
// ---------------------------------------------------------------------------
module ctrl_lgc (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] D,
    input  logic       a0,
    input  logic       wrflg,
    input  logic       rdflag,
    input  logic       inta,
    input  logic [7:0] R,
    input  logic [7:0] Mask,
    input  logic       isr,
    input  logic       irr,
    input  logic       isprior,
    input  logic       S,
    input  logic       CLsig,
    output logic       intr,
    output logic       ino,
    output logic       en,
    output logic [2:0] rwadr,
    output logic [2:0] Y,
    output logic       buff,
    output logic       LTIM,
    output logic       eoi,
    output logic       ar
);

    typedef enum logic [2:0] {
        IDLE_UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } init_state_e;

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK1,
        ACK2
    } ack_state_e;

    localparam logic [2:0] RW_ICW1 = 3'd0;
    localparam logic [2:0] RW_ICW2 = 3'd1;
    localparam logic [2:0] RW_ICW3 = 3'd2;
    localparam logic [2:0] RW_ICW4 = 3'd3;
    localparam logic [2:0] RW_OCW1 = 3'd4;
    localparam logic [2:0] RW_OCW2 = 3'd5;
    localparam logic [2:0] RW_OCW3 = 3'd6;
    localparam logic [2:0] RW_NONE = 3'd7;

    init_state_e init_q, init_d;
    ack_state_e  ack_q, ack_d;

    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic       buff_q, buff_d;
    logic [7:3] t_q, t_d;
    logic [2:0] rwadr_q, rwadr_d;
    logic       intr_q, intr_d;
    logic       ino_q, ino_d;
    logic       en_q, en_d;
    logic       eoi_q, eoi_d;
    logic       inta_q;

    logic       is_ready;
    logic       wr_icw1, wr_icw2, wr_icw3, wr_icw4;
    logic       wr_ocw1, wr_ocw2, wr_ocw3;
    logic       inta_rise, inta_fall;
    logic       aeoi_fire;
    logic [7:0] masked_req;
    logic [2:0] lowest_idx;

    // The vector base (T) feeds the vector driver outside this block and
    // D[2] carries no meaning for any command decoded here.
    logic       unused_bits;
    assign unused_bits = ^{t_q, D[2]};

    // Command decode. ICW1 is recognised in every state because it restarts
    // initialisation; the remaining ICWs follow the sequence, and OCWs only
    // exist once initialisation has completed.
    assign is_ready  = (init_q == READY);
    assign wr_icw1   = wrflg & ~a0 & D[4];
    assign wr_icw2   = wrflg &  a0 & (init_q == WAIT_ICW2);
    assign wr_icw3   = wrflg &  a0 & (init_q == WAIT_ICW3);
    assign wr_icw4   = wrflg &  a0 & (init_q == WAIT_ICW4);
    assign wr_ocw1   = wrflg &  a0 & is_ready;
    assign wr_ocw2   = wrflg & ~a0 & is_ready & (D[4:3] == 2'b00);
    assign wr_ocw3   = wrflg & ~a0 & is_ready & (D[4:3] == 2'b01);

    assign inta_rise = inta & ~inta_q;
    assign inta_fall = ~inta & inta_q;

    // Initialisation sequencer and mode flags. After ICW2 the path skips
    // ICW3 in single mode and skips ICW4 when ICW1 said it is not coming.
    always_comb begin
        init_d = init_q;
        ltim_d = ltim_q;
        sngl_d = sngl_q;
        ic4_d  = ic4_q;
        buff_d = buff_q;
        t_d    = t_q;
        if (wr_icw1) begin
            ltim_d = D[3];
            sngl_d = D[1];
            ic4_d  = D[0];
            buff_d = 1'b0;
            init_d = WAIT_ICW2;
        end else if (wr_icw2) begin
            t_d = D[7:3];
            if (!sngl_q) begin
                init_d = WAIT_ICW3;
            end else if (ic4_q) begin
                init_d = WAIT_ICW4;
            end else begin
                init_d = READY;
            end
        end else if (wr_icw3) begin
            init_d = ic4_q ? WAIT_ICW4 : READY;
        end else if (wr_icw4) begin
            buff_d = D[3];
            init_d = READY;
        end
    end

`ifdef CTRL_LGC_AEOI_EN
    logic ar_q, ar_d;

    // Automatic-EOI mode flag, cleared by ICW1 and loaded from ICW4 D1.
    always_comb begin
        ar_d = ar_q;
        if (wr_icw1) begin
            ar_d = 1'b0;
        end else if (wr_icw4) begin
            ar_d = D[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q <= 1'b0;
        end else begin
            ar_q <= ar_d;
        end
    end

    assign ar = ar_q;
`else
    assign ar = 1'b0;
`endif

    // INTA handshake. A fresh ICW1 tears down any handshake in progress,
    // and acknowledges are ignored until the controller is initialised.
    // The automatic EOI fires on the falling edge that ends the vector cycle.
    always_comb begin
        ack_d     = ack_q;
        ino_d     = 1'b0;
        aeoi_fire = 1'b0;
        if (wr_icw1) begin
            ack_d = ACK_IDLE;
        end else if (is_ready) begin
            case (ack_q)
                ACK_IDLE: begin
                    if (inta_rise) begin
                        ack_d = ACK1;
                        ino_d = 1'b1;
                    end
                end
                ACK1: begin
                    if (inta_rise) begin
                        ack_d = ACK2;
                    end
                end
                ACK2: begin
                    if (inta_fall) begin
                        ack_d     = ACK_IDLE;
                        aeoi_fire = ar;
                    end
                end
                default: begin
                    ack_d = ACK_IDLE;
                end
            endcase
        end else begin
            ack_d = ACK_IDLE;
        end
    end

    // Registered handshake outputs are computed from next-state values so
    // intr drops on the same edge that starts the acknowledge and en tracks
    // the second INTA pulse. A slave drives the bus only when cascaded in.
    // OCW2 EOI and automatic EOI landing together produce a single pulse.
    always_comb begin
        intr_d = (init_d == READY) & irr & (~isr | isprior) & (ack_d == ACK_IDLE);
        en_d   = (ack_d == ACK2) & inta & (S | CLsig);
        eoi_d  = (wr_ocw2 & D[5]) | aeoi_fire;
    end

    // Register address tracking: writes report the decoded target (or none),
    // reads always point at the OCW3-selected status register.
    always_comb begin
        rwadr_d = rwadr_q;
        if (wrflg) begin
            if (wr_icw1) begin
                rwadr_d = RW_ICW1;
            end else if (wr_icw2) begin
                rwadr_d = RW_ICW2;
            end else if (wr_icw3) begin
                rwadr_d = RW_ICW3;
            end else if (wr_icw4) begin
                rwadr_d = RW_ICW4;
            end else if (wr_ocw1) begin
                rwadr_d = RW_OCW1;
            end else if (wr_ocw2) begin
                rwadr_d = RW_OCW2;
            end else if (wr_ocw3) begin
                rwadr_d = RW_OCW3;
            end else begin
                rwadr_d = RW_NONE;
            end
        end else if (rdflag) begin
            rwadr_d = RW_OCW3;
        end
    end

    // Lowest-numbered unmasked request wins; scanning from the top lets the
    // last hit be the lowest index.
    always_comb begin
        masked_req = R & ~Mask;
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked_req[i]) begin
                lowest_idx = i[2:0];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q  <= IDLE_UNINIT;
            ack_q   <= ACK_IDLE;
            ltim_q  <= 1'b0;
            sngl_q  <= 1'b0;
            ic4_q   <= 1'b0;
            buff_q  <= 1'b0;
            t_q     <= 5'd0;
            rwadr_q <= RW_NONE;
            intr_q  <= 1'b0;
            ino_q   <= 1'b0;
            en_q    <= 1'b0;
            eoi_q   <= 1'b0;
            inta_q  <= 1'b0;
        end else begin
            init_q  <= init_d;
            ack_q   <= ack_d;
            ltim_q  <= ltim_d;
            sngl_q  <= sngl_d;
            ic4_q   <= ic4_d;
            buff_q  <= buff_d;
            t_q     <= t_d;
            rwadr_q <= rwadr_d;
            intr_q  <= intr_d;
            ino_q   <= ino_d;
            en_q    <= en_d;
            eoi_q   <= eoi_d;
            inta_q  <= inta;
        end
    end

    assign intr  = intr_q;
    assign ino   = ino_q;
    assign en    = en_q;
    assign eoi   = eoi_q;
    assign rwadr = rwadr_q;
    assign buff  = buff_q;
    assign LTIM  = ltim_q;
    assign Y     = lowest_idx;

endmodule

// File: tb/tb_ctrl_lgc.sv
// ---------------------------------------------------------------------------
// tb_ctrl_lgc
//
// Directed, table-driven bench for ctrl_lgc. Each table row gives the inputs
// for one clock cycle and the outputs expected after that cycle's rising
// edge. Inputs change on the falling edge and outputs are sampled on the
// following falling edge. A hand-written sequence covers reset asserted in
// the middle of an INTA handshake.
// ---------------------------------------------------------------------------
module tb_ctrl_lgc;

`ifdef CTRL_LGC_AEOI_EN
    localparam logic AE = 1'b1;
`else
    localparam logic AE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] D;
    logic       a0;
    logic       wrflg;
    logic       rdflag;
    logic       inta;
    logic [7:0] R;
    logic [7:0] Mask;
    logic       isr;
    logic       irr;
    logic       isprior;
    logic       S;
    logic       CLsig;
    logic       intr;
    logic       ino;
    logic       en;
    logic [2:0] rwadr;
    logic [2:0] Y;
    logic       buff;
    logic       LTIM;
    logic       eoi;
    logic       ar;

    int tests_run;
    int tests_failed;

    // ins  = {wrflg, a0, rdflag, inta, irr, isr, isprior, S, CLsig}
    // outs = {intr, ino, en, buff, LTIM, eoi, ar}
    typedef struct {
        logic [8:0] ins;
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] mask;
        logic [6:0] outs;
        logic [2:0] rw;
        logic [2:0] y;
    } vec_t;

    vec_t vecs[$];

    ctrl_lgc dut (
        .clk     (clk),
        .reset   (reset),
        .D       (D),
        .a0      (a0),
        .wrflg   (wrflg),
        .rdflag  (rdflag),
        .inta    (inta),
        .R       (R),
        .Mask    (Mask),
        .isr     (isr),
        .irr     (irr),
        .isprior (isprior),
        .S       (S),
        .CLsig   (CLsig),
        .intr    (intr),
        .ino     (ino),
        .en      (en),
        .rwadr   (rwadr),
        .Y       (Y),
        .buff    (buff),
        .LTIM    (LTIM),
        .eoi     (eoi),
        .ar      (ar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [8:0] ins, input logic [7:0] d,
                                input logic [7:0] r, input logic [7:0] mask,
                                input logic [6:0] outs, input logic [2:0] rw,
                                input logic [2:0] y);
        vec_t v;
        v.ins  = ins;
        v.d    = d;
        v.r    = r;
        v.mask = mask;
        v.outs = outs;
        v.rw   = rw;
        v.y    = y;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic got, input logic want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic checkVal3(input string name, input logic [2:0] got, input logic [2:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        {wrflg, a0, rdflag, inta, irr, isr, isprior, S, CLsig} = v.ins;
        D    = v.d;
        R    = v.r;
        Mask = v.mask;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkBit({tag, ".intr"}, intr, v.outs[6]);
        checkBit({tag, ".ino"},  ino,  v.outs[5]);
        checkBit({tag, ".en"},   en,   v.outs[4]);
        checkBit({tag, ".buff"}, buff, v.outs[3]);
        checkBit({tag, ".LTIM"}, LTIM, v.outs[2]);
        checkBit({tag, ".eoi"},  eoi,  v.outs[1]);
        checkBit({tag, ".ar"},   ar,   v.outs[0]);
        checkVal3({tag, ".rwadr"}, rwadr, v.rw);
        checkVal3({tag, ".Y"},     Y,     v.y);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Before initialisation: strobes and INTA are all ignored.
        vecs.push_back(mk(9'b000000010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        vecs.push_back(mk(9'b100110010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        vecs.push_back(mk(9'b000000010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        // ICW1 0x1B, ICW2 0x20, ICW4 0x0B
        vecs.push_back(mk(9'b100000010, 8'h1B, 8'h00, 8'h00, 7'b0000100, 3'd0, 3'd0));
        vecs.push_back(mk(9'b110000010, 8'h20, 8'h00, 8'h00, 7'b0000100, 3'd1, 3'd0));
        vecs.push_back(mk(9'b110000010, 8'h0B, 8'h00, 8'h00, {6'b000110, AE}, 3'd3, 3'd0));
        // Read strobe, then request/priority patterns
        vecs.push_back(mk(9'b001000010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd6, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'hCC, 8'h00, {6'b100110, AE}, 3'd6, 3'd2));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'hCC, 8'h04, {6'b100110, AE}, 3'd6, 3'd3));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h80, 8'h00, {6'b100110, AE}, 3'd6, 3'd7));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'hFF, 8'hFF, {6'b100110, AE}, 3'd6, 3'd0));
        vecs.push_back(mk(9'b000011010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd6, 3'd0));
        vecs.push_back(mk(9'b000011110, 8'h00, 8'h00, 8'h00, {6'b100110, AE}, 3'd6, 3'd0));
        vecs.push_back(mk(9'b000000010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd6, 3'd0));
        // OCW2 EOI, OCW1, OCW3, OCW2 without EOI
        vecs.push_back(mk(9'b100000010, 8'h20, 8'h00, 8'h00, {6'b000111, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000000010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b110000010, 8'hFF, 8'h00, 8'h00, {6'b000110, AE}, 3'd4, 3'd0));
        vecs.push_back(mk(9'b100000010, 8'h08, 8'h00, 8'h00, {6'b000110, AE}, 3'd6, 3'd0));
        vecs.push_back(mk(9'b100000010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        // Master handshake
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b100110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b010110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b001110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b001110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {5'b10011, AE, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b100110, AE}, 3'd5, 3'd0));
        // Slave, not cascaded in: no bus drive
        vecs.push_back(mk(9'b000110000, 8'h00, 8'h00, 8'h00, {6'b010110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010000, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110000, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010000, 8'h00, 8'h00, 8'h00, {5'b10011, AE, AE}, 3'd5, 3'd0));
        // Slave, cascaded in
        vecs.push_back(mk(9'b000110001, 8'h00, 8'h00, 8'h00, {6'b010110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010001, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110001, 8'h00, 8'h00, 8'h00, {6'b001110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010001, 8'h00, 8'h00, 8'h00, {5'b10011, AE, AE}, 3'd5, 3'd0));
        // ICW1 0x13 during ACK2 aborts the handshake
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b010110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b000110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b001110, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b100110010, 8'h13, 8'h00, 8'h00, 7'b0000000, 3'd0, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd0, 3'd0));
        // Re-init via ICW2 0x20, ICW4 0x02; OCW2 EOI coincides with AEOI
        vecs.push_back(mk(9'b110010010, 8'h20, 8'h00, 8'h00, 7'b0000000, 3'd1, 3'd0));
        vecs.push_back(mk(9'b110010010, 8'h02, 8'h00, 8'h00, {6'b100000, AE}, 3'd3, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b010000, AE}, 3'd3, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b000000, AE}, 3'd3, 3'd0));
        vecs.push_back(mk(9'b000110010, 8'h00, 8'h00, 8'h00, {6'b001000, AE}, 3'd3, 3'd0));
        vecs.push_back(mk(9'b100010010, 8'h20, 8'h00, 8'h00, {6'b100001, AE}, 3'd5, 3'd0));
        vecs.push_back(mk(9'b000010010, 8'h00, 8'h00, 8'h00, {6'b100000, AE}, 3'd5, 3'd0));

        // Reset state
        reset = 1'b1;
        applyStimulus(mk(9'b000000010, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        repeat (2) @(negedge clk);
        checkOutput("reset", mk(9'b0, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted asynchronously while the vector cycle is active.
        applyStimulus(mk(9'b000110010, 8'h00, 8'h00, 8'h00, 7'b0, 3'd0, 3'd0));
        @(negedge clk);
        inta = 1'b0;
        @(negedge clk);
        inta = 1'b1;
        @(negedge clk);
        checkBit("midreset.en_before", en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset", mk(9'b0, 8'h00, 8'h00, 8'h00, 7'b0000000, 3'd7, 3'd0));
        @(negedge clk);
        reset = 1'b0;
        inta  = 1'b0;
        repeat (2) @(negedge clk);
        checkBit("postreset.intr", intr, 1'b0);
        checkVal3("postreset.rwadr", rwadr, 3'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
